// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter sharing one SD sector channel between NUM_REQ level-held clients.
// Latency: grant, command and latched lba appear one edge after a request is seen in IDLE; ack/buff_wr/buff_din paths are combinational.
// Backpressure: a granted client holds the channel until the host ack falls; other requests wait.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_lba/req_rd/req_wr        per-client sector address and level-held read/write request
//   req_ack/req_buff_wr          per-client ack and buffer write strobe (owner only)
//   req_buff_din                 per-client write data towards the host
//   sd_lba/sd_rd/sd_wr           command to the host
//   sd_ack/sd_buff_wr            host ack and buffer write strobe
//   sd_buff_din                  owner's write data to the host (0 when nobody owns the channel)
//   grant/busy                   one-hot owner and transaction-in-flight flag
//   timeout_err                  sticky ack-timeout flag
//
// Optional build macro SD_ARB_TIMEOUT_EN: aborts a command that sees no ack within
// 2**TIMEOUT_W-1 ISSUE cycles. Without it timeout_err is tied low and ISSUE waits forever.
module sd_sector_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int TIMEOUT_W = 24
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [32*NUM_REQ-1:0]  req_lba,
    input  logic [NUM_REQ-1:0]     req_rd,
    input  logic [NUM_REQ-1:0]     req_wr,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     req_buff_wr,
    input  logic [8*NUM_REQ-1:0]   req_buff_din,
    output logic [31:0]            sd_lba,
    output logic                   sd_rd,
    output logic                   sd_wr,
    input  logic                   sd_ack,
    input  logic                   sd_buff_wr,
    output logic [7:0]             sd_buff_din,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t               r_state,  w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant,  w_grant_nxt;
    logic [31:0]          r_lba,    w_lba_nxt;
    logic                 r_rd,     w_rd_nxt;
    logic                 r_wr,     w_wr_nxt;
    logic                 r_busy,   w_busy_nxt;
    logic [PTR_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [PTR_W-1:0]     r_owner,  w_owner_nxt;
    logic                 r_old_ack;

    logic [NUM_REQ-1:0]   w_pending;
    logic                 w_found;
    logic [PTR_W-1:0]     w_pick;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [31:0]          w_pick_lba;
    logic                 w_pick_wr;
    logic                 w_active;

`ifdef SD_ARB_TIMEOUT_EN
    // Timeout fires on the edge where the counter reaches all-ones.
    localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] r_to_cnt, w_to_cnt_nxt;
    logic                 r_to_err, w_to_err_nxt;
`endif

    assign w_pending = req_rd | req_wr;

    // Round-robin pick: first pass looks at indices >= rr_ptr, the second
    // pass (wrap-around) only matters when the first found nothing.
    always_comb begin
        w_found    = 1'b0;
        w_pick     = '0;
        w_pick_oh  = '0;
        w_pick_lba = '0;
        w_pick_wr  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_pending[i] && (i >= int'(r_rr_ptr))) begin
                w_found      = 1'b1;
                w_pick       = PTR_W'(i);
                w_pick_oh    = '0;
                w_pick_oh[i] = 1'b1;
                w_pick_lba   = req_lba[32*i +: 32];
                w_pick_wr    = req_wr[i];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_pending[i]) begin
                w_found      = 1'b1;
                w_pick       = PTR_W'(i);
                w_pick_oh    = '0;
                w_pick_oh[i] = 1'b1;
                w_pick_lba   = req_lba[32*i +: 32];
                w_pick_wr    = req_wr[i];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_lba_nxt    = r_lba;
        w_rd_nxt     = r_rd;
        w_wr_nxt     = r_wr;
        w_busy_nxt   = r_busy;
        w_rr_ptr_nxt = r_rr_ptr;
        w_owner_nxt  = r_owner;
`ifdef SD_ARB_TIMEOUT_EN
        w_to_cnt_nxt = r_to_cnt;
        w_to_err_nxt = r_to_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_ISSUE;
                    w_grant_nxt = w_pick_oh;
                    w_lba_nxt   = w_pick_lba;
                    // rd and wr held together: the write wins.
                    w_wr_nxt    = w_pick_wr;
                    w_rd_nxt    = ~w_pick_wr;
                    w_busy_nxt  = 1'b1;
                    w_owner_nxt = w_pick;
`ifdef SD_ARB_TIMEOUT_EN
                    w_to_cnt_nxt = '0;
`endif
                end
            end
            ST_ISSUE: begin
                if (sd_ack) begin
                    w_rd_nxt    = 1'b0;
                    w_wr_nxt    = 1'b0;
                    w_state_nxt = ST_XFER;
                end
`ifdef SD_ARB_TIMEOUT_EN
                else if (r_to_cnt == TO_LAST) begin
                    // Client never saw ack, so its request stays pending and
                    // is re-arbitrated after the pointer moves past it.
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                    w_rd_nxt     = 1'b0;
                    w_wr_nxt     = 1'b0;
                    w_to_err_nxt = 1'b1;
                    w_state_nxt  = ST_RELEASE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
`endif
            end
            ST_XFER: begin
                if (r_old_ack && !sd_ack) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_grant_nxt  = '0;
                w_busy_nxt   = 1'b0;
                w_rr_ptr_nxt = (r_owner == LAST_IDX) ? '0 : r_owner + PTR_W'(1);
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_lba     <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_old_ack <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
            r_to_cnt  <= '0;
            r_to_err  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_lba     <= w_lba_nxt;
            r_rd      <= w_rd_nxt;
            r_wr      <= w_wr_nxt;
            r_busy    <= w_busy_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_old_ack <= sd_ack;
`ifdef SD_ARB_TIMEOUT_EN
            r_to_cnt  <= w_to_cnt_nxt;
            r_to_err  <= w_to_err_nxt;
`endif
        end
    end

    // Host ack/strobe reach the owner only while its command is live, so a
    // stray ack in IDLE or RELEASE is invisible to every client.
    assign w_active    = (r_state == ST_ISSUE) || (r_state == ST_XFER);
    assign req_ack     = r_grant & {NUM_REQ{sd_ack & w_active}};
    assign req_buff_wr = r_grant & {NUM_REQ{sd_buff_wr & w_active}};

    always_comb begin
        sd_buff_din = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                sd_buff_din = req_buff_din[8*i +: 8];
            end
        end
    end

    assign sd_lba = r_lba;
    assign sd_rd  = r_rd;
    assign sd_wr  = r_wr;
    assign grant  = r_grant;
    assign busy   = r_busy;

`ifdef SD_ARB_TIMEOUT_EN
    assign timeout_err = r_to_err;
`else
    // Tied low; the replication keeps TIMEOUT_W referenced in this build.
    assign timeout_err = |{TIMEOUT_W{1'b0}};
`endif

endmodule
